// File: rtl/online_fuzzy_pkg.sv
// ---------------------------------------------------------------------------
// online_fuzzy_pkg
// Shared types and constants for the online (MSD-first, bit-serial) fuzzy
// rule engine.
//   cmp_state_e  : per-rule online comparator state
//   MODE_MAXMIN  : aggregate = max over rules of min(in1, in2)
//   MODE_MINMAX  : aggregate = min over rules of max(in1, in2)
//   PIPE_LATENCY : cycles from an input digit to its result digit
// ---------------------------------------------------------------------------
package online_fuzzy_pkg;

    typedef enum logic [1:0] {
        CMP_EQ     = 2'd0,
        CMP_IN1_LT = 2'd1,
        CMP_IN2_LT = 2'd2
    } cmp_state_e;

    localparam int MODE_MAXMIN  = 0;
    localparam int MODE_MINMAX  = 1;
    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/online_cmp_select.sv
// ---------------------------------------------------------------------------
// online_cmp_select
// Two-input online min/max selector for MSD-first unsigned fractions.
// Emits one registered result digit per accepted input digit.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  synchronous, active-high
//   i_en    in  an input digit is accepted this cycle
//   i_first in  the accepted digit is the MSD (clears the comparator)
//   i_in1   in  digit of operand 1
//   i_in2   in  digit of operand 2
//   o_bit   out registered selected digit (min for MODE 0, max for MODE 1)
// ---------------------------------------------------------------------------
module online_cmp_select
    import online_fuzzy_pkg::*;
#(
    parameter int MODE = MODE_MAXMIN
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_first,
    input  logic i_in1,
    input  logic i_in2,
    output logic o_bit
);

    localparam logic SEL_MIN = (MODE == MODE_MAXMIN);

    cmp_state_e r_state;
    logic       r_bit;
    cmp_state_e w_state_eff;
    cmp_state_e w_state_next;
    logic       w_bit;

    // Next comparator state and selected digit; the MSD restarts from EQ.
    always_comb begin
        w_state_eff  = i_first ? CMP_EQ : r_state;
        w_state_next = w_state_eff;
        w_bit        = i_in1;
        case (w_state_eff)
            CMP_EQ: begin
                if (i_in1 != i_in2) begin
                    // First differing digit decides the order for the rest
                    // of the frame; the smaller operand holds the 0 here.
                    w_state_next = i_in1 ? CMP_IN2_LT : CMP_IN1_LT;
                    w_bit        = SEL_MIN ? 1'b0 : 1'b1;
                end else begin
                    w_state_next = CMP_EQ;
                    w_bit        = i_in1;
                end
            end
            CMP_IN1_LT: w_bit = SEL_MIN ? i_in1 : i_in2;
            CMP_IN2_LT: w_bit = SEL_MIN ? i_in2 : i_in1;
            default: begin
                w_state_next = CMP_EQ;
                w_bit        = i_in1;
            end
        endcase
    end

    // Comparator state and output digit registers, advanced per accepted digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CMP_EQ;
            r_bit   <= 1'b0;
        end else if (i_en) begin
            r_state <= w_state_next;
            r_bit   <= w_bit;
        end else begin
            r_state <= r_state;
            r_bit   <= r_bit;
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/online_fuzzy_rule_engine.sv
// ---------------------------------------------------------------------------
// online_fuzzy_rule_engine
// Evaluates NUM_RULES two-antecedent fuzzy rules on MSD-first bit-serial
// unsigned fractions. Stage 1 (one selector per rule) forms min/max of each
// rule's operands; stage 2 aggregates across rules with a shrinking
// candidate mask and reports the lowest surviving rule as the winner.
// Ports:
//   clock             in  rising-edge clock
//   reset             in  synchronous, active-high
//   io_start          in  MSD of a frame present (ignored while busy)
//   io_in1/io_in2     in  current digit per rule, bit r = rule r
//   io_busy           out frame in progress (digits 1..DIGITS-1)
//   io_outResultValid out io_outResult carries a valid digit
//   io_outResult      out result digit, MSD first
//   io_outLast        out final digit of the result frame
//   io_winnerIdx      out winning rule, updated with io_outLast and held
// ---------------------------------------------------------------------------
module online_fuzzy_rule_engine
    import online_fuzzy_pkg::*;
#(
    parameter int NUM_RULES = 4,
    parameter int DIGITS    = 8,
    parameter int MODE      = MODE_MAXMIN,
    parameter int IDX_W     = $clog2(NUM_RULES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic [NUM_RULES-1:0] io_in1,
    input  logic [NUM_RULES-1:0] io_in2,
    output logic                 io_busy,
    output logic                 io_outResultValid,
    output logic                 io_outResult,
    output logic                 io_outLast,
    output logic [IDX_W-1:0]     io_winnerIdx
);

    localparam int CNT_W = $clog2(DIGITS);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_first_in;
    logic                 w_accept;
    logic                 w_last_in;

    logic                 r_s1_valid;
    logic                 r_s1_first;
    logic                 r_s1_last;
    logic [NUM_RULES-1:0] w_s1_bits;

    logic [NUM_RULES-1:0] r_mask;
    logic                 r_out_valid;
    logic                 r_out_bit;
    logic                 r_out_last;
    logic [IDX_W-1:0]     r_winner;
    logic [NUM_RULES-1:0] w_mask_eff;
    logic [NUM_RULES-1:0] w_mask_next;
    logic                 w_out_bit;
    logic [IDX_W-1:0]     w_winner;

    // Lowest set index of a candidate mask; ties resolve to the lowest rule.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_RULES-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (m[r]) begin
                idx = IDX_W'(r);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Input framing: which digit (if any) is accepted this cycle.
    always_comb begin
        w_first_in = io_start & ~r_busy;
        w_accept   = w_first_in | r_busy;
        w_last_in  = r_busy & (r_cnt == CNT_W'(DIGITS - 1));
    end

    // Frame digit counter; busy covers digits 1..DIGITS-1 only, so a new
    // start is accepted on the cycle right after the last digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_first_in) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(1);
        end else if (w_last_in) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= r_cnt + CNT_W'(1);
        end else begin
            r_busy <= r_busy;
            r_cnt  <= r_cnt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RULES; g++) begin : g_rule
            online_cmp_select #(
                .MODE (MODE)
            ) u_cmp (
                .clock   (clock),
                .reset   (reset),
                .i_en    (w_accept),
                .i_first (w_first_in),
                .i_in1   (io_in1[g]),
                .i_in2   (io_in2[g]),
                .o_bit   (w_s1_bits[g])
            );
        end
    endgenerate

    // Stage-1 framing flags travel alongside the per-rule digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_first_in;
            r_s1_last  <= w_last_in;
        end
    end

    // Stage-2 aggregation: rules that fall behind the running max (or ahead
    // of the running min) leave the candidate mask, which can never empty.
    always_comb begin
        w_mask_eff  = r_s1_first ? {NUM_RULES{1'b1}} : r_mask;
        w_out_bit   = 1'b0;
        w_mask_next = w_mask_eff;
        if (MODE == MODE_MAXMIN) begin
            w_out_bit = |(w_s1_bits & w_mask_eff);
            if (w_out_bit) begin
                w_mask_next = w_mask_eff & w_s1_bits;
            end else begin
                w_mask_next = w_mask_eff;
            end
        end else begin
            w_out_bit = &(w_s1_bits | ~w_mask_eff);
            if (w_out_bit) begin
                w_mask_next = w_mask_eff;
            end else begin
                w_mask_next = w_mask_eff & ~w_s1_bits;
            end
        end
        w_winner = lowest_idx(w_mask_next);
    end

    // Stage-2 registers: result digit, flags, mask and held winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask      <= {NUM_RULES{1'b1}};
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            r_winner    <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_mask    <= w_mask_next;
                r_out_bit <= w_out_bit;
            end else begin
                r_mask    <= r_mask;
                r_out_bit <= r_out_bit;
            end
            if (r_s1_valid && r_s1_last) begin
                r_winner <= w_winner;
            end else begin
                r_winner <= r_winner;
            end
        end
    end

    assign io_busy           = r_busy;
    assign io_outResultValid = r_out_valid;
    assign io_outResult      = r_out_bit;
    assign io_outLast        = r_out_last;
    assign io_winnerIdx      = r_winner;

endmodule

// File: tb/tb_online_fuzzy_rule_engine.sv
// ---------------------------------------------------------------------------
// tb_online_fuzzy_rule_engine
// Drives one MODE 0 and one MODE 1 instance with identical digit streams and
// compares reassembled result frames against hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_online_fuzzy_rule_engine;
    import online_fuzzy_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_start = 1'b0;
    logic [3:0] io_in1 = 4'd0;
    logic [3:0] io_in2 = 4'd0;

    logic       o0_busy, o0_valid, o0_res, o0_last;
    logic [1:0] o0_win;
    logic       o1_busy, o1_valid, o1_res, o1_last;
    logic [1:0] o1_win;

    online_fuzzy_rule_engine #(.NUM_RULES(4), .DIGITS(8), .MODE(MODE_MAXMIN)) dut0 (
        .clock(clock), .reset(reset), .io_start(io_start), .io_in1(io_in1), .io_in2(io_in2),
        .io_busy(o0_busy), .io_outResultValid(o0_valid), .io_outResult(o0_res),
        .io_outLast(o0_last), .io_winnerIdx(o0_win));

    online_fuzzy_rule_engine #(.NUM_RULES(4), .DIGITS(8), .MODE(MODE_MINMAX)) dut1 (
        .clock(clock), .reset(reset), .io_start(io_start), .io_in1(io_in1), .io_in2(io_in2),
        .io_busy(o1_busy), .io_outResultValid(o1_valid), .io_outResult(o1_res),
        .io_outLast(o1_last), .io_winnerIdx(o1_win));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0][7:0] in1;
        logic [3:0][7:0] in2;
        logic [7:0]      mn_res;
        logic [1:0]      mn_win;
        logic [7:0]      mx_res;
        logic [1:0]      mx_win;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [1:0] win;
        int         first;
        int         ndig;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];
    logic [7:0] acc [2];
    int nd [2];
    int fc [2];
    int partial [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reassemble result frames from the serial outputs of one instance.
    task automatic mon(input int d, input logic v, input logic b, input logic l, input logic [1:0] w);
        frame_t f;
        if (v) begin
            if (nd[d] == 0) fc[d] = cyc;
            acc[d] = {acc[d][6:0], b};
            nd[d]++;
            if (l) begin
                f.res = acc[d]; f.win = w; f.first = fc[d]; f.ndig = nd[d];
                if (d == 0) q0.push_back(f); else q1.push_back(f);
                nd[d] = 0;
            end
        end else if (nd[d] != 0) begin
            partial[d]++;
            nd[d] = 0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            acc[d] = 8'd0; nd[d] = 0; fc[d] = 0; partial[d] = 0;
        end
    end

    always begin
        @(posedge clock);
        #2;
        mon(0, o0_valid, o0_res, o0_last, o0_win);
        mon(1, o1_valid, o1_res, o1_last, o1_win);
    end

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] mnr, input logic [1:0] mnw,
                                input logic [7:0] mxr, input logic [1:0] mxw);
        vec_t v;
        v.in1 = a; v.in2 = b;
        v.mn_res = mnr; v.mn_win = mnw; v.mx_res = mxr; v.mx_win = mxw;
        return v;
    endfunction

    task automatic idle(input int n);
        io_start = 1'b0; io_in1 = 4'd0; io_in2 = 4'd0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Present one 8-digit frame; optional extra start pulse at digit pulse_at.
    task automatic drive_frame(input vec_t v, input int pulse_at, output int start_cyc);
        start_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            io_start = (k == 0) || (k == pulse_at);
            for (int r = 0; r < 4; r++) begin
                io_in1[r] = v.in1[r][7-k];
                io_in2[r] = v.in2[r][7-k];
            end
            check($sformatf("busy0_d%0d", k), {31'd0, o0_busy}, {31'd0, k != 0});
            check($sformatf("busy1_d%0d", k), {31'd0, o1_busy}, {31'd0, k != 0});
            @(posedge clock); #1;
        end
        io_start = 1'b0;
    endtask

    task automatic check_pop(input int d, input logic [7:0] er, input logic [1:0] ew,
                             input int ef, input string tag);
        frame_t f;
        int sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++; errors++;
            $display("FAIL %s_d%0d: no result frame, expected 0x%0h", tag, d, er);
            return;
        end
        f = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("%s_d%0d_res", tag, d), {24'd0, f.res}, {24'd0, er});
        check($sformatf("%s_d%0d_win", tag, d), {30'd0, f.win}, {30'd0, ew});
        check($sformatf("%s_d%0d_first", tag, d), f.first, ef + PIPE_LATENCY);
        check($sformatf("%s_d%0d_ndig", tag, d), f.ndig, 32'd8);
    endtask

    vec_t vecs[7];
    int   sc;
    int   sc2;

    initial begin
        // in1/in2 packed as {rule3, rule2, rule1, rule0}
        vecs[0] = mk(32'h00FF30A0, 32'h1140F080, 8'h80, 2'd0, 8'h11, 2'd3);
        vecs[1] = mk(32'h55555555, 32'h55555555, 8'h55, 2'd0, 8'h55, 2'd0);
        vecs[2] = mk(32'h7F030201, 32'hFFFFFFFF, 8'h7F, 2'd3, 8'hFF, 2'd0);
        vecs[3] = mk(32'h00000000, 32'h00000000, 8'h00, 2'd0, 8'h00, 2'd0);
        vecs[4] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 2'd0, 8'hFF, 2'd0);
        vecs[5] = mk(32'h07C3C310, 32'h07FFC3C3, 8'hC3, 2'd1, 8'h07, 2'd3);
        vecs[6] = mk(32'h341200FF, 32'h123400FF, 8'h12, 2'd2, 8'h34, 2'd2);
        vecs[6].in1 = {8'h34, 8'h12, 8'hFF, 8'h00};
        vecs[6].in2 = {8'h12, 8'h34, 8'h00, 8'hFF};

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_valid0", {31'd0, o0_valid}, 32'd0);
        check("rst_last0",  {31'd0, o0_last},  32'd0);
        check("rst_res0",   {31'd0, o0_res},   32'd0);
        check("rst_win0",   {30'd0, o0_win},   32'd0);
        check("rst_busy0",  {31'd0, o0_busy},  32'd0);
        check("rst_valid1", {31'd0, o1_valid}, 32'd0);
        check("rst_win1",   {30'd0, o1_win},   32'd0);
        idle(2);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            drive_frame(vecs[i], -1, sc);
            idle(4);
            check_pop(0, vecs[i].mn_res, vecs[i].mn_win, sc, $sformatf("vec%0d", i));
            check_pop(1, vecs[i].mx_res, vecs[i].mx_win, sc, $sformatf("vec%0d", i));
        end

        // Back-to-back frames: 16 contiguous digits, no bubble
        drive_frame(vecs[0], -1, sc);
        drive_frame(vecs[2], -1, sc2);
        idle(4);
        check("b2b_spacing", sc2 - sc, 32'd8);
        check_pop(0, 8'h80, 2'd0, sc,  "b2bA");
        check_pop(0, 8'h7F, 2'd3, sc2, "b2bB");
        check_pop(1, 8'h11, 2'd3, sc,  "b2bA");
        check_pop(1, 8'hFF, 2'd0, sc2, "b2bB");

        // Start pulse mid-frame must be ignored
        drive_frame(vecs[0], 3, sc);
        idle(6);
        check("midstart_frames0", q0.size(), 32'd1);
        check("midstart_frames1", q1.size(), 32'd1);
        check_pop(0, 8'h80, 2'd0, sc, "midstart");
        check_pop(1, 8'h11, 2'd3, sc, "midstart");
        q0.delete(); q1.delete();

        // Reset asserted while digit 4 is presented
        io_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 4; r++) begin
                io_in1[r] = vecs[5].in1[r][7-k];
                io_in2[r] = vecs[5].in2[r][7-k];
            end
            if (k == 4) reset = 1'b1;
            @(posedge clock); #1;
            io_start = 1'b0;
        end
        check("rstmid_valid0", {31'd0, o0_valid}, 32'd0);
        check("rstmid_last0",  {31'd0, o0_last},  32'd0);
        check("rstmid_valid1", {31'd0, o1_valid}, 32'd0);
        check("rstmid_busy0",  {31'd0, o0_busy},  32'd0);
        reset = 1'b0;
        idle(8);
        check("rstmid_noframe0", q0.size(), 32'd0);
        check("rstmid_noframe1", q1.size(), 32'd0);
        check("rstmid_partial0", partial[0], 32'd1);
        check("rstmid_partial1", partial[1], 32'd1);

        // Fresh frame after reset
        drive_frame(vecs[5], -1, sc);
        idle(4);
        check_pop(0, 8'hC3, 2'd1, sc, "postrst");
        check_pop(1, 8'h07, 2'd3, sc, "postrst");

        check("end_partial0", partial[0], 32'd1);
        check("end_partial1", partial[1], 32'd1);
        check("end_extra0", q0.size(), 32'd0);
        check("end_extra1", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
